// File: rtl/ctrl_code_pkg.sv
// Shared types and constants for the control-code issuer and its command FIFO.
package ctrl_code_pkg;

  localparam int unsigned CODE_W    = 7;
  localparam int unsigned CMD_RPT_W = 4;

  // Bit positions of the decoder inputs inside a control code
  localparam int unsigned PI0 = 0;
  localparam int unsigned PI1 = 1;
  localparam int unsigned PI2 = 2;
  localparam int unsigned PI3 = 3;
  localparam int unsigned PI4 = 4;
  localparam int unsigned PI5 = 5;
  localparam int unsigned PI6 = 6;

  typedef struct packed {
    logic [CODE_W-1:0]    code;
    logic [CMD_RPT_W-1:0] rpt;
  } ctrl_cmd_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } issue_state_e;

endpackage

// File: rtl/ctrl_code_fifo.sv
// Synchronous command FIFO with a clear that takes priority over push and pop.
module ctrl_code_fifo
  import ctrl_code_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  ctrl_cmd_t                  wdata,
  input  logic                       pop,
  output ctrl_cmd_t                  rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  ctrl_cmd_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok & ~clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ctrl_code_issuer.sv
// Buffers code/repeat commands and issues each code rpt+1 times to the decoder.
module ctrl_code_issuer
  import ctrl_code_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RPT_W = CMD_RPT_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_code,
  input  logic [RPT_W-1:0]  cmd_rpt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_code,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  issue_state_e   state;
  ctrl_cmd_t      wdata;
  ctrl_cmd_t      head;
  logic           full;
  logic           empty;
  logic [AW:0]    count;
  logic [RPT_W-1:0] remain;
  logic           hs;
  logic           pop;

  assign wdata.code = cmd_code;
  assign wdata.rpt  = CMD_RPT_W'(cmd_rpt);
  assign cmd_ready  = ~full;
  assign busy       = (count != '0) | out_valid;
  assign hs         = out_valid & out_ready;

  // Pop when idle, or when the last beat of the current command is accepted
  assign pop = ~empty & ~flush &
               ((state == IDLE) | (hs & (remain == '0)));

  ctrl_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (cmd_valid & ~flush),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_last   <= 1'b0;
      remain     <= '0;
      issued_cnt <= '0;
    end else begin
      if (hs) issued_cnt <= issued_cnt + CNT_W'(1);
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        remain    <= '0;
      end else if (pop) begin
        state     <= ISSUE;
        out_valid <= 1'b1;
        out_code  <= head.code;
        remain    <= RPT_W'(head.rpt);
        out_last  <= (head.rpt == '0);
      end else if ((state == ISSUE) && hs) begin
        if (remain != '0) begin
          remain   <= remain - RPT_W'(1);
          out_last <= (remain == RPT_W'(1));
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_code_issuer.sv
// Directed scoreboard bench for ctrl_code_issuer.
module tb_ctrl_code_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_code;
  logic [3:0]  cmd_rpt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_code;
  logic        out_last;
  logic        busy;
  logic [15:0] issued_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] exp_cnt;
  int          beat_total;
  int          run;
  int          max_run;
  logic        have_stall;
  logic [6:0]  stall_code;
  logic        stall_last;
  logic        m_got;
  logic [7:0]  m_e;
  int          base;
  logic        reached;
  logic [3:0]  pat = 4'b1001;

  always #5 clk = ~clk;

  ctrl_code_issuer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_rpt    (cmd_rpt),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_last   (out_last),
    .busy       (busy),
    .issued_cnt (issued_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_code"},  32'(out_code),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_issued"},    32'(issued_cnt), 32'd0);
  endtask

  // Offer one command until accepted; expected beats join the scoreboard
  task automatic push(input logic [6:0] c, input logic [3:0] r);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_code  = c;
    cmd_rpt   = r;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        for (int b = 0; b <= int'(r); b++) exp_q.push_back({c, (b == int'(r))});
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Output monitor: beat scoreboard, counter model, stall stability
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt    = '0;
      have_stall = 1'b0;
      run        = 0;
    end else begin
      chk("issued_cnt", 32'(issued_cnt), 32'(exp_cnt));
      if (have_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_code",  32'(out_code),  32'(stall_code));
        chk("stall_last",  32'(out_last),  32'(stall_last));
      end
      if (out_valid) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
        m_got = (exp_q.size() != 0);
        chk("beat_expected", 32'(m_got), 32'd1);
        if (m_got) begin
          m_e = exp_q.pop_front();
          chk("beat_code", 32'(out_code), 32'(m_e[7:1]));
          chk("beat_last", 32'(out_last), 32'(m_e[0]));
        end
        exp_cnt = exp_cnt + 16'd1;
        beat_total++;
      end
      have_stall = out_valid && !out_ready;
      stall_code = out_code;
      stall_last = out_last;
      if (flush) begin
        exp_q.delete();
        have_stall = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_rpt = '0;
    flush = 1'b0; out_ready = 1'b0;
    exp_cnt = '0; beat_total = 0; run = 0; max_run = 0; have_stall = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single command, two-cycle first-beat latency
    out_ready = 1'b1;
    push(7'h1A, 4'd0);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    chk("lat_cycle2_code",  32'(out_code),  32'h1A);
    wait_idle(20);
    chk("single_cnt", 32'(issued_cnt), 32'd1);

    // Repeat under back-pressure 1,0,0,1
    push(7'h05, 4'd3);
    for (int i = 0; i < 16; i++) begin
      out_ready = pat[3 - (i % 4)];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle(40);
    chk("repeat_cnt", 32'(issued_cnt), 32'd5);

    // Back-to-back commands with no bubble
    max_run = 0;
    push(7'h11, 4'd1);
    push(7'h22, 4'd0);
    push(7'h33, 4'd2);
    wait_idle(40);
    chk("b2b_run", 32'(max_run), 32'd6);
    chk("b2b_cnt", 32'(issued_cnt), 32'd11);

    // Full FIFO behind a stalled issue register
    out_ready = 1'b0;
    push(7'h40, 4'd0);
    push(7'h41, 4'd0);
    push(7'h42, 4'd0);
    push(7'h43, 4'd0);
    push(7'h44, 4'd0);
    @(negedge clk);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy",  32'(busy),      32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_code = 7'h45; cmd_rpt = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fifth_refused", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_before_pop", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_pop", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    wait_idle(40);
    chk("full_cnt", 32'(issued_cnt), 32'd16);

    // Flush mid-repeat with two commands queued
    base = beat_total;
    push(7'h0F, 4'd9);
    push(7'h21, 4'd0);
    push(7'h32, 4'd0);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (beat_total - base >= 3) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("flush_reach", 32'(reached), 32'd1);
    flush = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy",  32'(busy),      32'd0);
    chk("flush_cnt",   32'(issued_cnt), 32'd19);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("flush_quiet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Counter wrap from a clean reset
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst2");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4095; k++) push(7'h3C, 4'd15);
    push(7'h3D, 4'd14);
    wait_idle(100);
    chk("cnt_allones", 32'(issued_cnt), 32'h0000FFFF);
    push(7'h2A, 4'd0);
    wait_idle(20);
    chk("cnt_wrapped", 32'(issued_cnt), 32'd0);

    // Asynchronous reset while a beat is pending
    out_ready = 1'b0;
    push(7'h55, 4'd5);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
